// File: rtl/spectrum_matrix_ps2_encoder.sv
// Diffs a 40-key Spectrum matrix against the state already reported downstream and emits
// paced MiSTer ps2_key press/release events. Define PS2ENC_DEBOUNCE_EN to add an input stability filter.
module spectrum_matrix_ps2_encoder #(
   parameter int unsigned GAP      = 1000,
   parameter int unsigned DEBOUNCE = 50000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [39:0] keys_in,
   input  logic        flush,
   output logic [10:0] ps2_key,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_WAIT} state_t;

   // EMIT plus the first scan slot already cover two cycles of the gap, so WAIT holds GAP-1.
   localparam logic [23:0] GAP_M1  = 24'(GAP - 1);
   localparam bit          NO_WAIT = (GAP <= 1);

   // Slot 0 is CAPS, slot 1 is SYMBOL SHIFT, then the remaining keys in bit order.
   function automatic logic [5:0] slot_bit(input logic [5:0] s);
      if (s == 6'd0)       return 6'd0;
      else if (s == 6'd1)  return 6'd36;
      else if (s <= 6'd36) return s - 6'd1;
      else                 return s;
   endfunction

   function automatic logic [7:0] key_code(input logic [5:0] b);
      case (b)
         6'd0:  return 8'h12;  6'd1:  return 8'h1A;  6'd2:  return 8'h22;  6'd3:  return 8'h21;
         6'd4:  return 8'h2A;  6'd5:  return 8'h1C;  6'd6:  return 8'h1B;  6'd7:  return 8'h23;
         6'd8:  return 8'h2B;  6'd9:  return 8'h34;  6'd10: return 8'h15;  6'd11: return 8'h1D;
         6'd12: return 8'h24;  6'd13: return 8'h2D;  6'd14: return 8'h2C;  6'd15: return 8'h16;
         6'd16: return 8'h1E;  6'd17: return 8'h26;  6'd18: return 8'h25;  6'd19: return 8'h2E;
         6'd20: return 8'h45;  6'd21: return 8'h46;  6'd22: return 8'h3E;  6'd23: return 8'h3D;
         6'd24: return 8'h36;  6'd25: return 8'h4D;  6'd26: return 8'h44;  6'd27: return 8'h43;
         6'd28: return 8'h3C;  6'd29: return 8'h35;  6'd30: return 8'h5A;  6'd31: return 8'h4B;
         6'd32: return 8'h42;  6'd33: return 8'h3B;  6'd34: return 8'h33;  6'd35: return 8'h29;
         6'd36: return 8'h14;  6'd37: return 8'h3A;  6'd38: return 8'h31;  6'd39: return 8'h32;
         default: return 8'h00;
      endcase
   endfunction

   logic [39:0] sync1_q, sync2_q, snap, sent_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= keys_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef PS2ENC_DEBOUNCE_EN
   logic [39:0] prev_q, snap_q;
   logic [23:0] db_cnt_q;

   // Any movement restarts the window; the snapshot only follows a matrix that sat still.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         prev_q   <= '1;
         snap_q   <= '1;
         db_cnt_q <= '0;
      end else begin
         prev_q <= sync2_q;
         if (sync2_q != prev_q)
            db_cnt_q <= 24'(DEBOUNCE);
         else if (db_cnt_q != 24'd0)
            db_cnt_q <= db_cnt_q - 24'd1;
         else
            snap_q <= prev_q;
      end
   end

   assign snap = snap_q;
`else
   assign snap = sync2_q;

   if (DEBOUNCE == 0) begin : g_no_filter
   end
`endif

   state_t      state_q;
   logic [5:0]  slot_q;
   logic [23:0] cnt_q;
   logic [10:0] ps2_q;
   logic        busy_q, flush_pend_q, flush_act_q;

   logic [5:0]  cur_bit;
   logic        target, differ, last_slot, step;

   always_comb begin
      cur_bit   = slot_bit(slot_q);
      target    = flush_pend_q | snap[cur_bit];
      differ    = sent_q[cur_bit] != target;
      last_slot = slot_q == 6'd39;
      step      = 1'b0;
      case (state_q)
         S_SCAN:  step = !differ;
         S_EMIT:  step = !differ || NO_WAIT;
         S_WAIT:  step = cnt_q <= 24'd1;
         default: step = 1'b0;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= S_IDLE;
         slot_q       <= '0;
         cnt_q        <= '0;
         sent_q       <= '1;
         ps2_q        <= '0;
         busy_q       <= 1'b0;
         flush_pend_q <= 1'b0;
         flush_act_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               slot_q <= '0;
               if (snap != sent_q || (flush_pend_q && sent_q != '1)) begin
                  state_q     <= S_SCAN;
                  busy_q      <= 1'b1;
                  flush_act_q <= flush_pend_q;
               end else if (flush_pend_q) begin
                  flush_pend_q <= 1'b0;
               end
            end
            S_SCAN: begin
               if (differ) state_q <= S_EMIT;
            end
            S_EMIT: begin
               // Re-evaluated here so a flush landing between SCAN and EMIT never lets a press out.
               if (differ) begin
                  ps2_q           <= {~ps2_q[10], ~target, 1'b0, key_code(cur_bit)};
                  sent_q[cur_bit] <= target;
                  cnt_q           <= GAP_M1;
                  state_q         <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 24'd1;
            end
            default: state_q <= S_IDLE;
         endcase

         // A pass only retires the flush if the flush was active from its first slot.
         if (step) begin
            if (last_slot) begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               if (flush_act_q) flush_pend_q <= 1'b0;
            end else begin
               slot_q  <= slot_q + 6'd1;
               state_q <= S_SCAN;
            end
         end

         if (flush) flush_pend_q <= 1'b1;
      end
   end

   assign ps2_key = ps2_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_spectrum_matrix_ps2_encoder.sv
// Scoreboard bench for spectrum_matrix_ps2_encoder: directed stimulus pushes expected events,
// a negedge monitor pops and compares on every ps2_key toggle.
module tb_spectrum_matrix_ps2_encoder;

   localparam int GAP = 4;
`ifdef PS2ENC_DEBOUNCE_EN
   localparam bit LAT_CHK = 1'b0;
`else
   localparam bit LAT_CHK = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic [39:0] keys = '0;
   logic [10:0] ps2_key;
   logic        busy;

   always #5 clk = ~clk;

   spectrum_matrix_ps2_encoder #(.GAP(GAP), .DEBOUNCE(8)) dut (
      .clk_sys (clk),
      .reset   (reset),
      .keys_in (keys),
      .flush   (flush),
      .ps2_key (ps2_key),
      .busy    (busy)
   );

   typedef struct {
      logic       press;
      logic [7:0] code;
      int         gap;   // expected cycles since previous event, 0 = unchecked
      int         at;    // expected absolute cycle, 0 = unchecked
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   logic prev_tog = 1'b0;

   logic [7:0] code_of [40] = '{
      8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,  8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
      8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,  8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
      8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,  8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
      8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,  8'h29, 8'h14, 8'h3A, 8'h31, 8'h32};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int slot_bit(input int s);
      if (s == 0)       return 0;
      else if (s == 1)  return 36;
      else if (s <= 36) return s - 1;
      else              return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic press, input int bitn, input int gap, input int at);
      q.push_back(exp_t'{press, code_of[bitn], gap, at});
   endtask

   // Wait for the scoreboard to empty, then idle long enough to catch any stray event.
   task automatic drain(input string name);
      int w = 0;
      while (q.size() != 0 && w < 2000) begin
         @(posedge clk);
         w++;
      end
      chk({name, "_drain"}, q.size(), 0);
      repeat (60) @(posedge clk);
      #1;
      chk({name, "_idle_busy"}, busy, 1'b0);
      q.delete();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_tog = ps2_key[10];
         end else if (ps2_key[10] !== prev_tog) begin
            prev_tog = ps2_key[10];
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_event: got %03h with nothing pending (cycle %0d)", ps2_key, cyc);
            end else begin
               e = q.pop_front();
               chk("event", ps2_key[9:0], {e.press, 1'b0, e.code});
               if (e.gap > 0) chk("spacing", cyc - last_cyc, e.gap);
               if (e.at > 0)  chk("latency", cyc, e.at);
            end
            last_cyc = cyc;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int w;
      // Reset with every key down, then expect 40 presses in scan order.
      reset = 1'b1;
      keys  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ps2_key", ps2_key, 11'h000);
      chk("reset_busy", busy, 1'b0);
      for (int s = 0; s < 40; s++)
         push(1'b1, slot_bit(s), (s == 0) ? 0 : GAP + 1, (s == 0 && LAT_CHK) ? cyc + 5 : 0);
      reset = 1'b0;
      drain("reset_presses");

      for (int s = 0; s < 40; s++)
         push(1'b0, slot_bit(s), (s == 0) ? 0 : GAP + 1, (s == 0 && LAT_CHK) ? cyc + 5 : 0);
      keys = '1;
      drain("all_release");

      // Single key Z (slot 2): 2 sync + 1 + 3 scan + 1 emit.
      push(1'b1, 1, 0, LAT_CHK ? cyc + 7 : 0);
      keys[1] = 1'b0;
      drain("z_press");
      push(1'b0, 1, 0, LAT_CHK ? cyc + 7 : 0);
      keys[1] = 1'b1;
      drain("z_release");

      // CAPS and C together: CAPS first, C three skipped slots later.
      push(1'b1, 0, 0, LAT_CHK ? cyc + 5 : 0);
      push(1'b1, 3, GAP + 1 + 3, 0);
      keys[0] = 1'b0;
      keys[3] = 1'b0;
      drain("modifier_press");
      push(1'b0, 0, 0, 0);
      push(1'b0, 3, GAP + 1 + 3, 0);
      keys[0] = 1'b1;
      keys[3] = 1'b1;
      drain("modifier_release");

      // Flush with Y (bit 29) and ENTER (bit 30) held.
      push(1'b1, 29, 0, 0);
      push(1'b1, 30, GAP + 1, 0);
      keys[29] = 1'b0;
      keys[30] = 1'b0;
      drain("flush_setup");
      push(1'b0, 29, 0, 0);
      push(1'b0, 30, GAP + 1, 0);
      push(1'b1, 29, 0, 0);
      push(1'b1, 30, GAP + 1, 0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      w = 0;
      while (busy !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
      chk("flush_busy_rise", busy, 1'b1);
      w = 0;
      while (busy !== 1'b0 && w < 500) begin @(posedge clk); #1; w++; end
      chk("flush_busy_fall", busy, 1'b0);
      chk("flush_pending_repress", q.size(), 2);
      drain("flush_repress");
      push(1'b0, 29, 0, 0);
      push(1'b0, 30, GAP + 1, 0);
      keys[29] = 1'b1;
      keys[30] = 1'b1;
      drain("flush_cleanup");

      // Reset while the gap counter is running after a release.
      push(1'b1, 1, 0, 0);
      keys[1] = 1'b0;
      drain("midwait_setup");
      push(1'b0, 1, 0, 0);
      keys[1] = 1'b1;
      w = 0;
      while (q.size() != 0 && w < 200) begin @(posedge clk); w++; end
      chk("midwait_release_seen", q.size(), 0);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midwait_reset_ps2_key", ps2_key, 11'h000);
      chk("midwait_reset_busy", busy, 1'b0);
      reset = 1'b0;
      drain("midwait_quiet");
      push(1'b1, 0, 0, LAT_CHK ? cyc + 5 : 0);
      keys[0] = 1'b0;
      drain("midwait_resume");
      push(1'b0, 0, 0, 0);
      keys[0] = 1'b1;
      drain("midwait_resume_release");

`ifdef PS2ENC_DEBOUNCE_EN
      // X bounces every 3 cycles for 30 cycles, then settles pressed.
      for (int i = 0; i < 10; i++) begin
         keys[2] = ~keys[2];
         repeat (3) @(posedge clk);
         #1;
      end
      push(1'b1, 2, 0, 0);
      keys[2] = 1'b0;
      drain("debounce_press");
      push(1'b0, 2, 0, 0);
      keys[2] = 1'b1;
      drain("debounce_release");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
